// File: rtl/mem_pkg.sv
// Shared bus widths and access-size encodings for the data memory,
// load/store unit and control unit.
package mem_pkg;

  localparam int BUS_WIDTH       = 32;
  localparam int MEM_VECTOR_SIZE = 256;

  localparam logic [1:0] BYTE      = 2'b00;
  localparam logic [1:0] HALF_WORD = 2'b01;
  localparam logic [1:0] WORD      = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // True when the access touches at least two bytes.
  function automatic logic size_has_half(input logic [1:0] sz);
    return (sz == HALF_WORD) || (sz == WORD);
  endfunction

  // True for a legal (non-reserved) access size.
  function automatic logic size_valid(input logic [1:0] sz);
    return sz != SIZE_RSVD;
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Sub-word select and sign/zero extension of a raw little-endian
// word gathered from memory starting at the access address.
module mem_extend
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = mem_pkg::BUS_WIDTH
) (
  input  logic [BUS_WIDTH-1:0] i_word,
  input  logic [1:0]           i_size,
  input  logic                 i_sz_ex,
  output logic [BUS_WIDTH-1:0] o_data
);

  logic w_bsign;
  logic w_hsign;

  assign w_bsign = i_sz_ex & i_word[7];
  assign w_hsign = i_sz_ex & i_word[15];

  // Pick the lane for the access size; the reserved size reads as zero.
  always_comb begin
    o_data = '0;
    unique case (i_size)
      BYTE:      o_data = {{(BUS_WIDTH-8){w_bsign}}, i_word[7:0]};
      HALF_WORD: o_data = {{(BUS_WIDTH-16){w_hsign}}, i_word[15:0]};
      WORD:      o_data = i_word;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem.sv
// Byte-addressable data memory, 32-bit bus, little-endian, wrapping
// address arithmetic, synchronous write and combinational read.
module mem
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = mem_pkg::BUS_WIDTH,
  parameter int MEM_BYTES = mem_pkg::MEM_VECTOR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] address,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 wr_en,
  input  logic [1:0]           mem_size,
  input  logic                 sz_ex,
  output logic [BUS_WIDTH-1:0] data_out
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    r_mem [MEM_BYTES];

  logic [AW-1:0] w_a0;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;
  logic [BUS_WIDTH-1:0] w_raw;
  logic          w_unused_addr;

  // Upper address bits alias onto the same bytes.
  assign w_a0 = address[AW-1:0];
  assign w_a1 = w_a0 + AW'(1);
  assign w_a2 = w_a0 + AW'(2);
  assign w_a3 = w_a0 + AW'(3);
  assign w_unused_addr = ^address[BUS_WIDTH-1:AW];

  // Store up to four bytes per edge; reset wipes the whole array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else if (wr_en && size_valid(mem_size)) begin
      r_mem[w_a0] <= data_in[7:0];
      if (size_has_half(mem_size)) begin
        r_mem[w_a1] <= data_in[15:8];
      end
      if (mem_size == WORD) begin
        r_mem[w_a2] <= data_in[23:16];
        r_mem[w_a3] <= data_in[31:24];
      end
    end
  end

  assign w_raw = {r_mem[w_a3], r_mem[w_a2],
                  r_mem[w_a1], r_mem[w_a0]};

  mem_extend #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_extend (
    .i_word (w_raw),
    .i_size (mem_size),
    .i_sz_ex(sz_ex),
    .o_data (data_out)
  );

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed vector table, hand-written
// reset/read-during-write sequences, and random traffic vs a byte model.
module tb_mem;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        wr_en;
  logic [1:0]  mem_size;
  logic        sz_ex;
  logic [31:0] data_out;

  int total;
  int bad;

  byte unsigned model [256];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    bit          sx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  mem dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data_in (data_in),
    .wr_en   (wr_en),
    .mem_size(mem_size),
    .sz_ex   (sz_ex),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  function automatic logic [31:0] model_read(
    input logic [31:0] a, input logic [1:0] sz, input bit sx);
    int n;
    longint unsigned v;
    int base;
    if (sz == 2'b11) return 32'h0;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a % 256);
    v = 0;
    for (int k = 0; k < n; k++)
      v = v + (longint'(model[(base + k) % 256]) << (8 * k));
    if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v + (longint'(32'hFFFF_FFFF) - ((longint'(1) << (8 * n)) - 1));
    return v[31:0];
  endfunction

  task automatic model_write(
    input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n;
    int base;
    if (sz == 2'b11) return;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(a % 256);
    for (int k = 0; k < n; k++)
      model[(base + k) % 256] = byte'((d >> (8 * k)) & 32'hFF);
  endtask

  task automatic check(input string name, input logic [31:0] exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: addr=%h size=%0d sx=%0d got=%h want=%h",
               name, address, mem_size, sz_ex, data_out, exp);
    end
  endtask

  task automatic do_write(
    input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    @(negedge clk);
    address  = a;
    data_in  = d;
    mem_size = sz;
    wr_en    = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model_write(a, d, sz);
  endtask

  task automatic do_read(
    input string name, input logic [31:0] a, input logic [1:0] sz,
    input bit sx, input logic [31:0] exp);
    address  = a;
    mem_size = sz;
    sz_ex    = sx;
    #1;
    check(name, exp);
  endtask

  task automatic add(
    input bit w, input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] sz, input bit sx, input logic [31:0] e,
    input string nm);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d;
    v.size = sz; v.sx = sx; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk_en = 1'b0;
    address = '0; data_in = '0; wr_en = 1'b0;
    mem_size = 2'b10; sz_ex = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    add(1, 0,   32'h0000_00FF, 2'b10, 0, 0, "w0");
    add(1, 4,   32'h0000_FFFF, 2'b00, 0, 0, "w4b");
    add(1, 8,   32'h00FF_FFFF, 2'b10, 0, 0, "w8");
    add(0, 4,   0, 2'b10, 0, 32'h0000_00FF, "rd4_word");
    add(0, 8,   0, 2'b10, 0, 32'h00FF_FFFF, "rd8_word");
    add(0, 0,   0, 2'b00, 1, 32'hFFFF_FFFF, "rd0_byte_sx");
    add(0, 0,   0, 2'b00, 0, 32'h0000_00FF, "rd0_byte_zx");
    add(0, 4,   0, 2'b01, 0, 32'h0000_00FF, "rd4_half_zx");
    add(1, 12,  32'hFFFF_FFFF, 2'b10, 0, 0, "w12");
    add(0, 12,  0, 2'b01, 0, 32'h0000_FFFF, "rd12_half_zx");
    add(0, 12,  0, 2'b01, 1, 32'hFFFF_FFFF, "rd12_half_sx");
    add(0, 12,  0, 2'b11, 1, 32'h0000_0000, "rd12_rsvd");
    add(1, 12,  32'h0000_0000, 2'b11, 0, 0, "w12_rsvd");
    add(0, 12,  0, 2'b10, 0, 32'hFFFF_FFFF, "rd12_after_rsvd");
    add(0, 32'h0100_000C, 0, 2'b10, 0, 32'hFFFF_FFFF, "alias12");
    add(1, 254, 32'h1122_3344, 2'b10, 0, 0, "w254");
    add(0, 254, 0, 2'b00, 0, 32'h0000_0044, "wrap_b254");
    add(0, 255, 0, 2'b00, 0, 32'h0000_0033, "wrap_b255");
    add(0, 0,   0, 2'b00, 0, 32'h0000_0022, "wrap_b0");
    add(0, 1,   0, 2'b00, 0, 32'h0000_0011, "wrap_b1");
    add(0, 0,   0, 2'b10, 0, 32'h0000_1122, "wrap_w0");
    add(0, 254, 0, 2'b10, 0, 32'h1122_3344, "wrap_w254");

    rst = 1'b1;
    #20;
    rst = 1'b0;
    #1;
    do_read("reset_w0",   0,   2'b10, 0, 32'h0);
    do_read("reset_w4",   4,   2'b10, 0, 32'h0);
    do_read("reset_w8",   8,   2'b10, 0, 32'h0);
    do_read("reset_w255", 255, 2'b10, 0, 32'h0);
    clk_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].size);
      end else begin
        @(negedge clk);
        do_read(vecs[i].name, vecs[i].addr, vecs[i].size,
                vecs[i].sx, vecs[i].exp);
      end
    end

    // Read during write to the same address.
    @(negedge clk);
    address = 20; mem_size = 2'b10; sz_ex = 1'b0;
    data_in = 32'hA5C3_5A3C; wr_en = 1'b1;
    #1;
    check("rdw_before", 32'h0);
    @(posedge clk);
    #1;
    check("rdw_after", 32'hA5C3_5A3C);
    wr_en = 1'b0;
    model_write(20, 32'hA5C3_5A3C, 2'b10);

    // Asynchronous reset between edges, then a write held under reset.
    @(negedge clk);
    address = 12; mem_size = 2'b10;
    #2;
    check("pre_async_rst", 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    check("async_rst_now", 32'h0);
    data_in = 32'hDEAD_BEEF; wr_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_beats_wr", 32'h0);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    #1;
    check("post_rst_w12", 32'h0);

    // Idempotent repeated write.
    @(negedge clk);
    address = 40; data_in = 32'h1357_9BDF; mem_size = 2'b10; wr_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wr_en = 1'b0;
    model_write(40, 32'h1357_9BDF, 2'b10);
    check("hold_wr", 32'h1357_9BDF);

    // Random traffic against the byte-array model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      logic [31:0] rd;
      logic [1:0]  rs;
      bit          rx;
      ra = $urandom;
      rd = $urandom;
      rs = 2'($urandom_range(0, 3));
      rx = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        do_write(ra, rd, rs);
      end else begin
        @(negedge clk);
        do_read("rand_rd", ra, rs, rx, model_read(ra, rs, rx));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem.md
Name: mem

Overview:
- Byte-addressable 2 Kbit (256 x 8) data memory with a 32-bit data bus for the multi-cycle RISC-V core.
- Supports byte, half-word and word accesses, little-endian.
- Writes are synchronous on the clock edge.
- Reads are combinational, with selectable sign or zero extension of sub-word loads.

Parameters:
- BUS_WIDTH, 32, width of address, data_in and data_out.
- MEM_BYTES, 256, number of byte locations; must be a power of two.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset; clears all memory bytes.
- address  input  32  byte address; only the low log2(MEM_BYTES)=8 bits are used.
- data_in  input  32  store data, right-aligned; only the low 8/16/32 bits are used per mem_size.
- wr_en  input  1  1 = write on the next rising clk edge; 0 = read only.
- mem_size  input  2  00 = byte, 01 = half word, 10 = word, 11 = reserved.
- sz_ex  input  1  1 = sign-extend sub-word reads; 0 = zero-extend.
- data_out  output  32  read data for the current address and mem_size.

Behaviour:
- Reset:
  - rst high (asynchronous, any time) immediately forces every byte to 8'h00.
  - data_out therefore reads 0 while and after reset.
  - rst dominates wr_en; a write coincident with reset is discarded.
- Write, on the rising clk edge with rst low and wr_en=1:
  - Let A = address[7:0].
  - mem[A] <= data_in[7:0] for all sizes.
  - Half word and word also: mem[A+1] <= data_in[15:8].
  - Word also: mem[A+2] <= data_in[23:16] and mem[A+3] <= data_in[31:24].
- mem_size=11: no write occurs, and data_out = 0.
- Address arithmetic A+k wraps modulo MEM_BYTES (byte 255 is followed by byte 0).
- Unaligned accesses are permitted; no alignment trap.
- Read is combinational, with no clock latency. data_out updates whenever address, mem_size, sz_ex or the memory contents change, including the read-during-write case.
- Read data by mem_size:
  - byte: b = mem[A]; data_out = {24{sz_ex & b[7]}, b}.
  - half word: h = {mem[A+1], mem[A]}; data_out = {16{sz_ex & h[15]}, h}.
  - word: data_out = {mem[A+3], mem[A+2], mem[A+1], mem[A]}; sz_ex is ignored.
- Read during write, same address: before the edge data_out shows the old contents; after the edge it shows the new contents.
- wr_en is level-sampled. Holding it high for N edges rewrites the same data N times (idempotent).
- Upper address bits [31:8] are ignored (aliasing).
- No X propagation from memory: storage is always reset-initialised.

Decomposition:
- Shared package holds:
  - BUS_WIDTH = 32
  - MEM_VECTOR_SIZE = 256
  - size encodings WORD = 2'b10, HALF_WORD = 2'b01, BYTE = 2'b00
- These are also used by the load/store unit and the control unit.
- One optional sub-module, mem_extend: pure combinational sub-word select plus sign/zero extension (inputs: raw 32-bit word, mem_size, sz_ex).
- Storage and write logic stay in mem.

Test Plan:
- Reset then idle: pulse rst for 20 ns with no clock edge in between -> data_out = 0x00000000 for word reads at 0, 4, 8 and 255.
- Word write 0x000000FF at 0; byte write 0x0000FFFF at 4; word write 0x00FFFFFF at 8:
  - word read at 4 -> 0x000000FF (upper byte of data_in dropped);
  - word read at 8 -> 0x00FFFFFF.
- Byte read at 0 with sz_ex=1 -> 0xFFFFFFFF; same read with sz_ex=0 -> 0x000000FF.
- Half-word read at 4 with sz_ex=0 -> 0x000000FF.
- Word write 0xFFFFFFFF at 12, then half-word read at 12:
  - sz_ex=0 -> 0x0000FFFF;
  - sz_ex=1 -> 0xFFFFFFFF.
- Wrap and reset mid-operation:
  - word write 0x11223344 at 254 -> byte reads return 254 = 0x44, 255 = 0x33, 0 = 0x22, 1 = 0x11.
  - Assert rst asynchronously between edges -> data_out = 0 immediately, before the next clk edge.
